// File: rtl/soc_apb_timer_capture_pkg.sv
// Shared types and default sizing for the APB timer input-capture unit.
package soc_apb_timer_capture_pkg;

    localparam int unsigned DEFAULT_DEPTH      = 4;
    localparam int unsigned DEFAULT_FILTER_LEN = 3;
    localparam int unsigned TS_W               = 32;

    typedef logic [TS_W-1:0] timestamp_t;

    typedef enum logic [1:0] {
        EDGE_NONE = 2'b00,
        EDGE_RISE = 2'b01,
        EDGE_FALL = 2'b10,
        EDGE_BOTH = 2'b11
    } edge_sel_e;

endpackage : soc_apb_timer_capture_pkg

// File: rtl/soc_apb_timer_capture_if.sv
// Register-side bundle of the capture unit: control in, buffer head and flags out.
interface soc_apb_timer_capture_if
    import soc_apb_timer_capture_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_DEPTH
) ();

    localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

    logic             enable_i;
    logic [1:0]       edge_sel_i;
    logic             clear_i;
    logic             pop_i;
    timestamp_t       capture_value_o;
    logic             capture_valid_o;
    logic [LVL_W-1:0] level_o;
    logic             overflow_o;
    logic             irq_o;

    // Register block side: drives control, reads the buffer.
    modport master (
        output enable_i, edge_sel_i, clear_i, pop_i,
        input  capture_value_o, capture_valid_o, level_o, overflow_o, irq_o
    );

    // Capture unit side.
    modport slave (
        input  enable_i, edge_sel_i, clear_i, pop_i,
        output capture_value_o, capture_valid_o, level_o, overflow_o, irq_o
    );

endinterface : soc_apb_timer_capture_if

// File: rtl/soc_apb_timer_capture_sync.sv
// Event pin front end: 2-flop synchronizer, optional stability filter, edge detector.
// Filter is built only when SOC_APB_TIMER_CAPTURE_FILTER_EN is defined.
module soc_apb_timer_capture_sync #(
    parameter int unsigned FILTER_LEN = 3
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic i_capture,
    output logic o_rise_c,
    output logic o_fall_c
);

    if (FILTER_LEN < 1) begin : g_bad_filter_len
        $error("FILTER_LEN must be at least 1");
    end

    logic r_sync1;
    logic r_sync2;
    logic r_dly;
    logic w_filt;

    // Bring the asynchronous pin into the clock domain.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_capture;
            r_sync2 <= r_sync1;
        end
    end

`ifdef SOC_APB_TIMER_CAPTURE_FILTER_EN
    localparam int unsigned CNT_W = $clog2(FILTER_LEN + 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_filt;

    // Move the filtered level only after FILTER_LEN consecutive cycles at the new level.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt  <= '0;
            r_filt <= 1'b0;
        end else if (r_sync2 == r_filt) begin
            r_cnt  <= '0;
        end else if (r_cnt == CNT_W'(FILTER_LEN - 1)) begin
            r_cnt  <= '0;
            r_filt <= r_sync2;
        end else begin
            r_cnt  <= r_cnt + CNT_W'(1);
        end
    end

    assign w_filt = r_filt;
`else
    assign w_filt = r_sync2;
`endif

    // Previous filtered level; runs regardless of enable so enabling never fakes an edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_dly <= 1'b0;
        end else begin
            r_dly <= w_filt;
        end
    end

    assign o_rise_c = w_filt & ~r_dly;
    assign o_fall_c = ~w_filt & r_dly;

endmodule : soc_apb_timer_capture_sync

// File: rtl/soc_apb_timer_capture.sv
// APB timer input-capture unit: timestamps selected pin edges into a FWFT buffer.
// Optional glitch filter enabled by SOC_APB_TIMER_CAPTURE_FILTER_EN.
module soc_apb_timer_capture
    import soc_apb_timer_capture_pkg::*;
#(
    parameter int unsigned DEPTH      = DEFAULT_DEPTH,
    parameter int unsigned FILTER_LEN = DEFAULT_FILTER_LEN
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  timestamp_t                    counter_value_i,
    input  logic                          capture_i,
    soc_apb_timer_capture_if.slave        bus
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned LVL_W = AW + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("DEPTH must be a power of two, at least 2");
    end

    timestamp_t       r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             r_overflow;
    logic             r_irq;

    logic             w_rise;
    logic             w_fall;
    edge_sel_e        w_sel;
    logic             w_hit;
    logic             w_push_req;
    logic             w_pop;
    logic             w_push;
    logic             w_drop;
    logic [LVL_W-1:0] w_level;
    logic             w_empty;
    logic             w_full;

    soc_apb_timer_capture_sync #(
        .FILTER_LEN (FILTER_LEN)
    ) u_sync (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .i_capture (capture_i),
        .o_rise_c  (w_rise),
        .o_fall_c  (w_fall)
    );

    // Occupancy from pointer difference; the wrap bit separates full from empty.
    assign w_level = LVL_W'(r_wr_ptr - r_rd_ptr);
    assign w_empty = (w_level == '0);
    assign w_full  = (w_level == LVL_W'(DEPTH));

    // Edge selection and push/pop arbitration against buffer state.
    always_comb begin
        w_sel      = edge_sel_e'(bus.edge_sel_i);
        w_hit      = 1'b0;
        unique case (w_sel)
            EDGE_RISE: w_hit = w_rise;
            EDGE_FALL: w_hit = w_fall;
            EDGE_BOTH: w_hit = w_rise | w_fall;
            default:   w_hit = 1'b0;
        endcase
        w_push_req = bus.enable_i & w_hit;
        w_pop      = bus.pop_i & ~w_empty;
        w_push     = w_push_req & (~w_full | w_pop);
        w_drop     = w_push_req & w_full & ~w_pop;
    end

    // Pointers, sticky overflow and capture interrupt; clear beats push and pop.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_overflow <= 1'b0;
            r_irq      <= 1'b0;
        end else if (bus.clear_i) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_overflow <= 1'b0;
            r_irq      <= 1'b0;
        end else begin
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
            r_irq <= w_push;
        end
    end

    // Timestamp storage; contents are masked at the output while empty.
    always_ff @(posedge clk_i) begin
        if (!bus.clear_i && w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= counter_value_i;
        end
    end

    assign bus.capture_value_o = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
    assign bus.capture_valid_o = ~w_empty;
    assign bus.level_o         = w_level;
    assign bus.overflow_o      = r_overflow;
    assign bus.irq_o           = r_irq;

endmodule : soc_apb_timer_capture

// File: doc/soc_apb_timer_capture.md
# soc_apb_timer_capture

Input-capture unit for the SoC APB timer: the read-side counterpart to the compare/match counter. It watches an external asynchronous event pin and records the shared timer count at each selected edge into a small first-word-fall-through buffer. Software pops entries through the APB register block. It sits beside the timer counter, taking that counter's current value as its timebase.

## Interface
- DEPTH, 4: capture buffer entries; power of two, ≥2.
- FILTER_LEN, 3: cycles the synchronized input must be stable before an edge is accepted; used only with the filter macro; ≥1.
- clk_i  input  1  system clock
- rst_ni  input  1  reset; asynchronous, active-low
- enable_i  input  1  capture enable; edges are recorded only while high
- edge_sel_i  input  2  00 none, 01 rising, 10 falling, 11 both
- clear_i  input  1  synchronous flush of the buffer and of overflow_o
- counter_value_i  input  32  live timer count, from the timer counter
- capture_i  input  1  external event pin, asynchronous to clk_i
- pop_i  input  1  consume the head entry (APB read strobe)
- capture_value_o  output  32  head entry; 0 when empty
- capture_valid_o  output  1  buffer non-empty
- level_o  output  $clog2(DEPTH)+1  number of stored entries
- overflow_o  output  1  sticky flag: an edge was dropped because the buffer was full
- irq_o  output  1  one-cycle pulse on every successful capture write

## Operation
- Input path: two-flop synchronizer, then (optionally) the glitch filter, then a one-flop delayed copy for edge detection.
- Rising edge = filtered value 1 and delayed value 0. Falling edge is the inverse.
- An edge is "selected" when it matches edge_sel_i. The synchronizer and edge history always run, including while enable_i=0 or edge_sel_i=00, so enabling never creates a false edge.
- Write: a selected edge with enable_i=1 pushes counter_value_i as sampled at the writing clock edge, and pulses irq_o.
- Buffer: circular, with read and write pointers of $clog2(DEPTH) bits plus a wrap bit. Pointers wrap modulo DEPTH.
- Full with a push and no pop: the new edge is discarded, the contents are unchanged, overflow_o is set, and there is no irq.
- Full with a push and a pop in the same cycle: both happen, there is no overflow, and level stays at DEPTH.
- Empty with a pop: the pop is ignored and the pointers do not move.
- Empty with a push and a pop in the same cycle: the push is accepted and the pop is ignored, so level becomes 1.
- overflow_o clears only on clear_i or reset.
- clear_i has priority over push and pop in the same cycle: the buffer empties, overflow_o clears, and the edge in that cycle is dropped with no irq.
- The counter value is stored as-is. Wrap of the timer (0xFFFFFFFF→0) is software's concern; no flag is kept for it.

## Timing
- Reset values: capture_value_o=0, capture_valid_o=0, level_o=0, overflow_o=0, irq_o=0. Synchronizer and filter flops reset to 0. The pointers reset to 0.
- Latency without the filter: a capture_i transition sampled at clock edge N is written at edge N+2. capture_valid_o and irq_o are high in the cycle after edge N+2, and the stored value is counter_value_i at edge N+2.
- With the filter: the write occurs FILTER_LEN edges later than that, and the stored value is counter_value_i at the writing edge.
- Pop: capture_value_o and level_o update in the cycle after the popping edge. The head is combinational from buffer storage, so there are no extra read wait cycles.
- Minimum spacing between two captured edges is one clock; back-to-back selected edges write on consecutive cycles.
- Reset mid-operation aborts everything immediately, including in-flight synchronizer state.

## Configuration
- SOC_APB_TIMER_CAPTURE_FILTER_EN.
- Defined: a FILTER_LEN-cycle stability counter sits after the synchronizer. The filtered value changes only after the synchronized input has held a new level for FILTER_LEN consecutive cycles, so pulses shorter than that are ignored.
- Undefined: the filter logic is absent, the synchronizer output feeds the edge detector directly, and FILTER_LEN is unused.

## Structure
- Package soc_apb_timer_capture_pkg holds:
  - the edge_sel enum (EDGE_NONE, EDGE_RISE, EDGE_FALL, EDGE_BOTH);
  - the default DEPTH and FILTER_LEN constants;
  - the 32-bit timestamp typedef.
- Sub-module soc_apb_timer_capture_sync contains the synchronizer, the optional filter and the edge detector. Its outputs are rise and fall pulses. The buffer and flag logic stay in the top module.

## Test plan
- Rising edges, edge_sel=01, counter ramping from 0x100: three pulses → three entries equal to the count at edge N+2 each. irq_o pulses 3×, level_o=3, and popping returns them in order with values 0 when empty.
- edge_sel=11, one high pulse of 5 cycles → two entries whose difference is 5. edge_sel=00 → no entries and no irq.
- DEPTH=4: five edges with no pops → level 4, the 5th edge dropped, overflow_o=1, the first four values intact. A following push+pop in the same cycle on the full buffer → accepted with no new overflow. clear_i → level 0 and overflow 0.
- enable_i low while capture_i is held high, then enable_i raised → no capture. A later falling edge with edge_sel=10 is captured.
- Filter on, FILTER_LEN=3: a 2-cycle glitch gives no capture; a 3-cycle-stable rise is captured 3 cycles later than the unfiltered latency.
- rst_ni asserted with 2 entries stored and an edge in flight → all outputs 0 immediately. After release, no spurious capture from the old edge.
